// File: rtl/cache_flush_ctrl.sv
// Cache flush controller: walks every (line, way) pair of one bank, issuing a
// flush request per pair, then waits for the writeback path to drain before
// reporting completion. Counts the dirty evictions the bank reports along the way.
module cache_flush_ctrl #(
    parameter int  LINES_PER_BANK = 64,
    parameter int  NUM_WAYS       = 4,
    localparam int LSB  = ($clog2(LINES_PER_BANK) > 1) ? $clog2(LINES_PER_BANK) : 1,
    localparam int CNTW = $clog2(LINES_PER_BANK * NUM_WAYS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_valid,
    output logic                start_ready,
    output logic                flush_valid,
    input  logic                flush_ready,
    output logic [LSB-1:0]      flush_line_sel,
    output logic [NUM_WAYS-1:0] flush_way_sel,
    input  logic                evict_valid,
    input  logic                wb_idle,
    output logic                done_valid,
    input  logic                done_ready,
    output logic                busy,
    output logic [CNTW-1:0]     evict_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LSB-1:0]      LAST_LINE = LSB'(LINES_PER_BANK - 1);
    localparam logic [NUM_WAYS-1:0] WAY_FIRST = NUM_WAYS'(1);

    state_t              state_q, state_d;
    logic [LSB-1:0]      line_q, line_d;
    logic [NUM_WAYS-1:0] way_q, way_d;
    logic [CNTW-1:0]     evict_count_q, evict_count_d;
    logic                start_ready_q, start_ready_d;
    logic                flush_valid_q, flush_valid_d;
    logic                done_valid_q, done_valid_d;
    logic                busy_q, busy_d;
    logic                flush_hs;

    assign flush_hs = flush_valid_q & flush_ready;

    // Next-state, walk position, eviction count and registered outputs.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        line_d        = line_q;
        way_d         = way_q;
        evict_count_d = evict_count_q;
        start_ready_d = start_ready_q;
        flush_valid_d = flush_valid_q;
        done_valid_d  = done_valid_q;
        busy_d        = busy_q;

        // Evictions only belong to the flush while it is walking or draining.
        if ((state_q == WALK || state_q == DRAIN) && evict_valid && (evict_count_q != '1)) begin
            evict_count_d = evict_count_q + CNTW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d       = WALK;
                    line_d        = '0;
                    way_d         = WAY_FIRST;
                    evict_count_d = '0;
                    start_ready_d = 1'b0;
                    flush_valid_d = 1'b1;
                    busy_d        = 1'b1;
                end
            end
            WALK: begin
                if (flush_hs) begin
                    if (way_q[NUM_WAYS-1]) begin
                        way_d = WAY_FIRST;
                        if (line_q == LAST_LINE) begin
                            // Last pair accepted: wrap the line and stop requesting.
                            line_d        = '0;
                            state_d       = DRAIN;
                            flush_valid_d = 1'b0;
                        end else begin
                            line_d = line_q + LSB'(1);
                        end
                    end else begin
                        way_d = way_q << 1;
                    end
                end
            end
            DRAIN: begin
                if (wb_idle) begin
                    state_d      = DONE;
                    done_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d       = IDLE;
                    done_valid_d  = 1'b0;
                    start_ready_d = 1'b1;
                    busy_d        = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset to an idle, empty walk.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q       <= IDLE;
            line_q        <= '0;
            way_q         <= WAY_FIRST;
            evict_count_q <= '0;
            start_ready_q <= 1'b1;
            flush_valid_q <= 1'b0;
            done_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            way_q         <= way_d;
            evict_count_q <= evict_count_d;
            start_ready_q <= start_ready_d;
            flush_valid_q <= flush_valid_d;
            done_valid_q  <= done_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign start_ready    = start_ready_q;
    assign flush_valid    = flush_valid_q;
    assign flush_line_sel = line_q;
    assign flush_way_sel  = way_q;
    assign done_valid     = done_valid_q;
    assign busy           = busy_q;
    assign evict_count    = evict_count_q;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Testbench for cache_flush_ctrl: directed scenarios plus a randomized run on a
// 4-line, 2-way instance checked cycle by cycle against a behavioural model,
// and a short directed run on a 1-line, 1-way instance.
module tb_cache_flush_ctrl;

    localparam int L    = 4;
    localparam int W    = 2;
    localparam int N    = L * W;
    localparam int LSBW = 2;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (4 lines, 2 ways)
    logic            reset, start_valid, flush_ready, evict_valid, wb_idle, done_ready;
    logic            start_ready, flush_valid, done_valid, busy;
    logic [LSBW-1:0] flush_line_sel;
    logic [W-1:0]    flush_way_sel;
    logic [CW-1:0]   evict_count;

    // Minimal instance (1 line, 1 way)
    logic       reset_b, start_valid_b, flush_ready_b, evict_valid_b, wb_idle_b, done_ready_b;
    logic       start_ready_b, flush_valid_b, done_valid_b, busy_b;
    logic [0:0] flush_line_sel_b;
    logic [0:0] flush_way_sel_b;
    logic [0:0] evict_count_b;

    cache_flush_ctrl #(.LINES_PER_BANK(L), .NUM_WAYS(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_valid    (start_valid),
        .start_ready    (start_ready),
        .flush_valid    (flush_valid),
        .flush_ready    (flush_ready),
        .flush_line_sel (flush_line_sel),
        .flush_way_sel  (flush_way_sel),
        .evict_valid    (evict_valid),
        .wb_idle        (wb_idle),
        .done_valid     (done_valid),
        .done_ready     (done_ready),
        .busy           (busy),
        .evict_count    (evict_count)
    );

    cache_flush_ctrl #(.LINES_PER_BANK(1), .NUM_WAYS(1)) dut_b (
        .clk            (clk),
        .reset          (reset_b),
        .start_valid    (start_valid_b),
        .start_ready    (start_ready_b),
        .flush_valid    (flush_valid_b),
        .flush_ready    (flush_ready_b),
        .flush_line_sel (flush_line_sel_b),
        .flush_way_sel  (flush_way_sel_b),
        .evict_valid    (evict_valid_b),
        .wb_idle        (wb_idle_b),
        .done_valid     (done_valid_b),
        .done_ready     (done_ready_b),
        .busy           (busy_b),
        .evict_count    (evict_count_b)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: which phase the flush is in, how many pairs have been
    // accepted, and how many evictions have been counted.
    typedef enum int {P_IDLE, P_WALK, P_DRAIN, P_DONE} phase_t;
    phase_t m_phase = P_IDLE;
    int     m_idx   = 0;
    int     m_cnt   = 0;

    // Flush handshakes observed on the main instance during the current command.
    int obs_line[$];
    int obs_way[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_phase = P_IDLE;
            m_idx   = 0;
            m_cnt   = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (start_valid) begin
                        m_phase = P_WALK;
                        m_idx   = 0;
                        m_cnt   = 0;
                    end
                end
                P_WALK: begin
                    if (evict_valid && m_cnt < CMAX) m_cnt++;
                    if (flush_ready) begin
                        m_idx++;
                        if (m_idx == N) m_phase = P_DRAIN;
                    end
                end
                P_DRAIN: begin
                    if (evict_valid && m_cnt < CMAX) m_cnt++;
                    if (wb_idle) m_phase = P_DONE;
                end
                P_DONE: begin
                    if (done_ready) m_phase = P_IDLE;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic compare_all();
        check("start_ready", 32'(start_ready), (m_phase == P_IDLE) ? 1 : 0);
        check("flush_valid", 32'(flush_valid), (m_phase == P_WALK) ? 1 : 0);
        check("done_valid", 32'(done_valid), (m_phase == P_DONE) ? 1 : 0);
        check("busy", 32'(busy), (m_phase != P_IDLE) ? 1 : 0);
        check("evict_count", 32'(evict_count), m_cnt);
        check("line_sel", 32'(flush_line_sel), (m_idx % N) / W);
        check("way_sel", 32'(flush_way_sel), 1 << (m_idx % W));
    endtask

    // Every completed command must have issued all pairs, line-major, way-minor.
    task automatic compare_seq();
        check("hs_total", obs_line.size(), N);
        for (int i = 0; i < obs_line.size() && i < N; i++) begin
            check($sformatf("hs%0d_line", i), obs_line[i], i / W);
            check($sformatf("hs%0d_way", i), obs_way[i], 1 << (i % W));
        end
    endtask

    // One clock: record handshakes, advance model, compare #1 after the edge.
    task automatic cycle();
        phase_t prev;
        if (!reset && m_phase == P_IDLE && start_valid) begin
            obs_line.delete();
            obs_way.delete();
        end
        if (!reset && flush_valid === 1'b1 && flush_ready) begin
            obs_line.push_back(int'(flush_line_sel));
            obs_way.push_back(int'(flush_way_sel));
        end
        @(posedge clk);
        prev = m_phase;
        model_step();
        cyc++;
        #1;
        compare_all();
        if (prev == P_DRAIN && m_phase == P_DONE) compare_seq();
    endtask

    task automatic wait_hs(input int n, input int budget);
        while (obs_line.size() < n && budget > 0) begin
            cycle();
            budget--;
        end
        check("wait_hs", obs_line.size(), n);
    endtask

    task automatic wait_done(input int budget);
        while (done_valid !== 1'b1 && budget > 0) begin
            cycle();
            budget--;
        end
        check("wait_done", 32'(done_valid), 1);
    endtask

    task automatic start_cmd();
        start_valid = 1'b1;
        cycle();
        start_valid = 1'b0;
    endtask

    task automatic ack_done();
        done_ready = 1'b1;
        cycle();
        done_ready = 1'b0;
    endtask

    initial begin
        int stall;
        int guard;

        reset = 1'b1; start_valid = 1'b0; flush_ready = 1'b1;
        evict_valid = 1'b0; wb_idle = 1'b1; done_ready = 1'b0;
        reset_b = 1'b1; start_valid_b = 1'b0; flush_ready_b = 1'b0;
        evict_valid_b = 1'b0; wb_idle_b = 1'b1; done_ready_b = 1'b0;

        // Reset state
        cycle();
        cycle();
        check("rst_start_ready", 32'(start_ready), 1);
        check("rst_flush_valid", 32'(flush_valid), 0);
        check("rst_done_valid", 32'(done_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_evict_count", 32'(evict_count), 0);
        check("rst_line", 32'(flush_line_sel), 0);
        check("rst_way", 32'(flush_way_sel), 1);
        check("rst_b_start_ready", 32'(start_ready_b), 1);
        check("rst_b_busy", 32'(busy_b), 0);
        reset = 1'b0;
        reset_b = 1'b0;
        cycle();

        // Full walk with no back-pressure; DONE two cycles after the last request
        start_cmd();
        wait_hs(N, 40);
        check("drain_flush_valid", 32'(flush_valid), 0);
        check("drain_done_valid", 32'(done_valid), 0);
        check("drain_busy", 32'(busy), 1);
        cycle();
        check("done_two_cycles", 32'(done_valid), 1);
        ack_done();
        check("idle_after_ack", 32'(start_ready), 1);

        // Three-cycle stall on pair (2, 10)
        start_cmd();
        stall = 3;
        guard = 40;
        while (obs_line.size() < N && guard > 0) begin
            if (m_phase == P_WALK && m_idx == 5 && stall > 0) begin
                flush_ready = 1'b0;
                stall--;
                check("stall_line", 32'(flush_line_sel), 2);
                check("stall_way", 32'(flush_way_sel), 2);
            end else begin
                flush_ready = 1'b1;
            end
            cycle();
            guard--;
        end
        flush_ready = 1'b1;
        check("stall_hs_total", obs_line.size(), N);
        wait_done(10);
        ack_done();

        // Five evictions while walking, one while draining, writeback busy 10 cycles
        start_cmd();
        guard = 40;
        while (obs_line.size() < N && guard > 0) begin
            evict_valid = (m_idx == 1 || m_idx == 3 || m_idx == 5 || m_idx == 6 || m_idx == 7);
            wb_idle = 1'b0;
            cycle();
            guard--;
        end
        evict_valid = 1'b0;
        check("walk_evicts", 32'(evict_count), 5);
        for (int i = 0; i < 10; i++) begin
            evict_valid = (i == 3);
            cycle();
            check("drain_wait_done", 32'(done_valid), 0);
        end
        evict_valid = 1'b0;
        wb_idle = 1'b1;
        cycle();
        check("done_on_wb_idle", 32'(done_valid), 1);
        check("evict_total", 32'(evict_count), 6);

        // Held completion ignores a new start
        done_ready = 1'b0;
        start_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("done_held", 32'(done_valid), 1);
            check("start_ignored", 32'(start_ready), 0);
        end
        start_valid = 1'b0;
        ack_done();
        check("ack_to_idle", 32'(start_ready), 1);
        check("count_held_idle", 32'(evict_count), 6);
        evict_valid = 1'b1;
        cycle();
        evict_valid = 1'b0;
        check("idle_evict_ignored", 32'(evict_count), 6);
        start_cmd();
        check("start_clears_count", 32'(evict_count), 0);

        // Reset after three handshakes aborts the flush
        evict_valid = 1'b1;
        wait_hs(3, 10);
        evict_valid = 1'b0;
        check("pre_abort_count", 32'(evict_count), 3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("abort_flush_valid", 32'(flush_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_evict_count", 32'(evict_count), 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("abort_no_done", 32'(done_valid), 0);
            check("abort_no_flush", 32'(flush_valid), 0);
        end
        start_cmd();
        check("restart_flush_valid", 32'(flush_valid), 1);
        check("restart_line", 32'(flush_line_sel), 0);
        check("restart_way", 32'(flush_way_sel), 1);
        wait_done(40);
        ack_done();

        // Eviction counter saturation under a long stall
        start_cmd();
        flush_ready = 1'b0;
        evict_valid = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        check("evict_saturate", 32'(evict_count), CMAX);
        evict_valid = 1'b0;
        flush_ready = 1'b1;
        wait_done(40);
        check("evict_saturate_held", 32'(evict_count), CMAX);
        ack_done();

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            reset       = ($urandom_range(0, 199) == 0);
            start_valid = ($urandom_range(0, 1) == 1);
            flush_ready = ($urandom_range(0, 3) != 0);
            evict_valid = ($urandom_range(0, 2) == 0);
            wb_idle     = ($urandom_range(0, 1) == 1);
            done_ready  = ($urandom_range(0, 2) == 0);
            cycle();
        end
        reset = 1'b0; start_valid = 1'b0; flush_ready = 1'b1;
        evict_valid = 1'b0; wb_idle = 1'b1; done_ready = 1'b1;

        // Single line, single way: one request (0,1), then DRAIN, then DONE
        start_valid_b = 1'b1;
        cycle();
        start_valid_b = 1'b0;
        check("b_flush_valid", 32'(flush_valid_b), 1);
        check("b_line", 32'(flush_line_sel_b), 0);
        check("b_way", 32'(flush_way_sel_b), 1);
        check("b_busy_walk", 32'(busy_b), 1);
        flush_ready_b = 1'b1;
        wb_idle_b = 1'b0;
        evict_valid_b = 1'b1;
        cycle();
        check("b_drain_flush_valid", 32'(flush_valid_b), 0);
        check("b_drain_busy", 32'(busy_b), 1);
        check("b_drain_done", 32'(done_valid_b), 0);
        check("b_evict_one", 32'(evict_count_b), 1);
        cycle();
        evict_valid_b = 1'b0;
        check("b_no_extra_request", 32'(flush_valid_b), 0);
        check("b_still_draining", 32'(done_valid_b), 0);
        check("b_evict_saturate", 32'(evict_count_b), 1);
        wb_idle_b = 1'b1;
        cycle();
        check("b_done_valid", 32'(done_valid_b), 1);
        check("b_done_flush_valid", 32'(flush_valid_b), 0);
        done_ready_b = 1'b1;
        cycle();
        done_ready_b = 1'b0;
        check("b_idle_start_ready", 32'(start_ready_b), 1);
        check("b_idle_busy", 32'(busy_b), 0);
        check("b_idle_done", 32'(done_valid_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound on total run time in case a wait loop is broken.
    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
